// File: rtl/reflect_ray_gen_pkg.sv
// ---------------------------------------------------------------------------
// reflect_ray_gen_pkg / light_pack
//
// Purpose: shared fixed-point geometry definitions for the ray reflection
// path, plus the lighting constants used as block defaults.
//
//   reflect_ray_gen_pkg : fixed_t (signed Q16.16), point_t, vector_t, ray_t,
//                         and fMul, the wrapping Q16.16 multiply.
//   light_pack          : FIXED_ONE, MAX_BOUNCE_DEFAULT, EPS_DEFAULT.
//
// Packed layouts: ray_t = {start, dir}; point_t/vector_t = {x, y, z}, with
// the first-named field in the most significant bits.
// ---------------------------------------------------------------------------
package reflect_ray_gen_pkg;

  typedef logic signed [31:0] fixed_t;

  typedef struct packed {
    fixed_t x;
    fixed_t y;
    fixed_t z;
  } point_t;

  typedef struct packed {
    fixed_t x;
    fixed_t y;
    fixed_t z;
  } vector_t;

  typedef struct packed {
    point_t  start;
    vector_t dir;
  } ray_t;

  // Full 64-bit signed product, arithmetic shift right by 16, keep the low
  // 32 bits. Overflow wraps rather than saturating.
  function automatic fixed_t fMul(input fixed_t a, input fixed_t b);
    return fixed_t'((64'(a) * 64'(b)) >>> 16);
  endfunction

endpackage

package light_pack;

  import reflect_ray_gen_pkg::*;

  localparam fixed_t      FIXED_ONE          = 32'sh0001_0000;
  localparam int unsigned MAX_BOUNCE_DEFAULT = 4;
  localparam logic [31:0] EPS_DEFAULT        = 32'h0000_0100;

endpackage

// File: rtl/reflect_ray_gen_vec_dot3.sv
// ---------------------------------------------------------------------------
// vec_dot3
//
// Purpose: registered 3-term fixed-point dot product (a.b). The result
// updates only when en is high, so the register can double as a stage
// of a stallable pipeline.
//
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   en       : load a new product this cycle
//   a, b     : operand vectors (Q16.16 per component)
//   dot      : registered a.x*b.x + a.y*b.y + a.z*b.z, wrapping at 32 bits
// ---------------------------------------------------------------------------
module vec_dot3
  import reflect_ray_gen_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    en,
  input  vector_t a,
  input  vector_t b,
  output fixed_t  dot
);

  fixed_t dot_d;
  fixed_t dot_q;

  // Each term is truncated by fMul before the sum, matching the per-op
  // wrapping semantics used everywhere else in the datapath.
  always_comb begin
    dot_d = dot_q;
    if (en) begin
      dot_d = fMul(a.x, b.x) + fMul(a.y, b.y) + fMul(a.z, b.z);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dot_q <= '0;
    end else begin
      dot_q <= dot_d;
    end
  end

  assign dot = dot_q;

endmodule

// File: rtl/reflect_ray_gen.sv
// ---------------------------------------------------------------------------
// reflect_ray_gen
//
// Purpose: turn an incident ray plus a surface hit (point, unit normal) into
// the mirror-reflected ray, or drop it once it has bounced too often.
//   dir'   = d - 2(d.n)n
//   start' = point + EPS*n   (nudged off the surface to avoid self-hits)
//
// Three-stage valid/ready pipeline, one beat per cycle, latency 3:
//   S1  dot  = d.n                        (vec_dot3)
//   S2  kn   = fMul(2*dot, n), en = fMul(EPS, n)
//   S3  out_ray = {point + en, d - kn}, out_depth = depth + 1
// All stages move together on advance = !out_valid || out_ready.
//
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : input handshake (in_ready == advance)
//   in_ray               : incident ray {start, dir}; start is not needed
//   in_point, in_normal  : hit point and unit surface normal
//   in_depth             : bounce depth of the incident ray
//   out_valid / out_ready: output handshake
//   out_ray, out_depth   : reflected ray and in_depth + 1
//   term_pulse           : one-cycle pulse per dropped (too deep) ray
//   ray_count            : wrapping count of reflected rays handed off
// ---------------------------------------------------------------------------
module reflect_ray_gen
  import reflect_ray_gen_pkg::*, light_pack::*;
#(
  parameter int unsigned MAX_BOUNCE = MAX_BOUNCE_DEFAULT,
  parameter logic [31:0] EPS        = EPS_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [191:0] in_ray,
  input  logic [95:0]  in_point,
  input  logic [95:0]  in_normal,
  input  logic [3:0]   in_depth,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [191:0] out_ray,
  output logic [3:0]   out_depth,
  output logic         term_pulse,
  output logic [15:0]  ray_count
);

  ray_t    in_ray_s;
  point_t  in_point_s;
  vector_t in_normal_s;

  assign in_ray_s    = in_ray;
  assign in_point_s  = in_point;
  assign in_normal_s = in_normal;

  // The incident start point plays no part in the reflection.
  logic unused_start;
  assign unused_start = ^in_ray_s.start;

  logic advance;
  logic accept;
  logic terminate;

  // Stage 1
  logic     s1_valid_d, s1_valid_q;
  vector_t  s1_dir_d,   s1_dir_q;
  point_t   s1_point_d, s1_point_q;
  vector_t  s1_normal_d, s1_normal_q;
  logic [3:0] s1_depth_d, s1_depth_q;
  fixed_t   s1_dot;

  // Stage 2
  logic     s2_valid_d, s2_valid_q;
  vector_t  s2_dir_d,   s2_dir_q;
  point_t   s2_point_d, s2_point_q;
  vector_t  s2_kn_d,    s2_kn_q;
  vector_t  s2_en_d,    s2_en_q;
  logic [3:0] s2_depth_d, s2_depth_q;
  fixed_t   two_dot;
  fixed_t   eps_fixed;

  // Stage 3 / output
  logic       out_valid_d, out_valid_q;
  ray_t       out_ray_d,   out_ray_q;
  logic [3:0] out_depth_d, out_depth_q;
  logic       term_pulse_d, term_pulse_q;
  logic [15:0] ray_count_d, ray_count_q;

  assign advance   = !out_valid_q || out_ready;
  assign in_ready  = advance;
  assign accept    = in_valid && advance;
  assign terminate = accept && ({28'd0, in_depth} >= MAX_BOUNCE);

  assign two_dot   = s1_dot <<< 1;
  assign eps_fixed = fixed_t'(EPS);

  vec_dot3 u_dot (
    .clk (clk),
    .rst (rst),
    .en  (advance),
    .a   (in_ray_s.dir),
    .b   (in_normal_s),
    .dot (s1_dot)
  );

  // Pipeline next-state: every stage holds unless advance is high. A
  // terminated beat is accepted (so the producer moves on) but enters S1 as
  // a bubble. The output register keeps its last ray across bubbles.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_dir_d    = s1_dir_q;
    s1_point_d  = s1_point_q;
    s1_normal_d = s1_normal_q;
    s1_depth_d  = s1_depth_q;

    s2_valid_d  = s2_valid_q;
    s2_dir_d    = s2_dir_q;
    s2_point_d  = s2_point_q;
    s2_kn_d     = s2_kn_q;
    s2_en_d     = s2_en_q;
    s2_depth_d  = s2_depth_q;

    out_valid_d = out_valid_q;
    out_ray_d   = out_ray_q;
    out_depth_d = out_depth_q;

    if (advance) begin
      s1_valid_d  = accept && !terminate;
      s1_dir_d    = in_ray_s.dir;
      s1_point_d  = in_point_s;
      s1_normal_d = in_normal_s;
      s1_depth_d  = in_depth;

      s2_valid_d  = s1_valid_q;
      s2_dir_d    = s1_dir_q;
      s2_point_d  = s1_point_q;
      s2_depth_d  = s1_depth_q;
      s2_kn_d.x   = fMul(two_dot, s1_normal_q.x);
      s2_kn_d.y   = fMul(two_dot, s1_normal_q.y);
      s2_kn_d.z   = fMul(two_dot, s1_normal_q.z);
      s2_en_d.x   = fMul(eps_fixed, s1_normal_q.x);
      s2_en_d.y   = fMul(eps_fixed, s1_normal_q.y);
      s2_en_d.z   = fMul(eps_fixed, s1_normal_q.z);

      out_valid_d = s2_valid_q;
      if (s2_valid_q) begin
        out_ray_d.dir.x   = s2_dir_q.x - s2_kn_q.x;
        out_ray_d.dir.y   = s2_dir_q.y - s2_kn_q.y;
        out_ray_d.dir.z   = s2_dir_q.z - s2_kn_q.z;
        out_ray_d.start.x = s2_point_q.x + s2_en_q.x;
        out_ray_d.start.y = s2_point_q.y + s2_en_q.y;
        out_ray_d.start.z = s2_point_q.z + s2_en_q.z;
        out_depth_d       = s2_depth_q + 4'd1;
      end
    end
  end

  // Side-band: termination pulse and handed-off ray counter (wraps at 16 bits).
  always_comb begin
    term_pulse_d = terminate;
    ray_count_d  = ray_count_q;
    if (out_valid_q && out_ready) begin
      ray_count_d = ray_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_dir_q     <= '0;
      s1_point_q   <= '0;
      s1_normal_q  <= '0;
      s1_depth_q   <= '0;
      s2_valid_q   <= 1'b0;
      s2_dir_q     <= '0;
      s2_point_q   <= '0;
      s2_kn_q      <= '0;
      s2_en_q      <= '0;
      s2_depth_q   <= '0;
      out_valid_q  <= 1'b0;
      out_ray_q    <= '0;
      out_depth_q  <= '0;
      term_pulse_q <= 1'b0;
      ray_count_q  <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_dir_q     <= s1_dir_d;
      s1_point_q   <= s1_point_d;
      s1_normal_q  <= s1_normal_d;
      s1_depth_q   <= s1_depth_d;
      s2_valid_q   <= s2_valid_d;
      s2_dir_q     <= s2_dir_d;
      s2_point_q   <= s2_point_d;
      s2_kn_q      <= s2_kn_d;
      s2_en_q      <= s2_en_d;
      s2_depth_q   <= s2_depth_d;
      out_valid_q  <= out_valid_d;
      out_ray_q    <= out_ray_d;
      out_depth_q  <= out_depth_d;
      term_pulse_q <= term_pulse_d;
      ray_count_q  <= ray_count_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_ray    = out_ray_q;
  assign out_depth  = out_depth_q;
  assign term_pulse = term_pulse_q;
  assign ray_count  = ray_count_q;

endmodule

// File: tb/tb_reflect_ray_gen.sv
// ---------------------------------------------------------------------------
// tb_reflect_ray_gen
//
// Directed bench for reflect_ray_gen: a table of hand-computed reflections
// applied one at a time, followed by hand-written sequences for stalls,
// termination, mid-flight reset and the ray counter wrap.
// ---------------------------------------------------------------------------
module tb_reflect_ray_gen;

  import reflect_ray_gen_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [191:0] in_ray;
  logic [95:0]  in_point;
  logic [95:0]  in_normal;
  logic [3:0]   in_depth;
  logic         out_valid;
  logic         out_ready;
  logic [191:0] out_ray;
  logic [3:0]   out_depth;
  logic         term_pulse;
  logic [15:0]  ray_count;

  int compared   = 0;
  int mismatched = 0;

  reflect_ray_gen dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_ray     (in_ray),
    .in_point   (in_point),
    .in_normal  (in_normal),
    .in_depth   (in_depth),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ray    (out_ray),
    .out_depth  (out_depth),
    .term_pulse (term_pulse),
    .ray_count  (ray_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    vector_t    dir;
    point_t     point;
    vector_t    normal;
    logic [3:0] depth;
    vector_t    exp_dir;
    point_t     exp_start;
    logic [3:0] exp_depth;
  } vec_rec_t;

  vec_rec_t vecs [7];

  function automatic vector_t mkv(input fixed_t x, input fixed_t y, input fixed_t z);
    vector_t v;
    v.x = x; v.y = y; v.z = z;
    return v;
  endfunction

  function automatic point_t mkp(input fixed_t x, input fixed_t y, input fixed_t z);
    point_t p;
    p.x = x; p.y = y; p.z = z;
    return p;
  endfunction

  function automatic vec_rec_t mkrec(input vector_t d, input point_t p, input vector_t n,
                                     input logic [3:0] dep, input vector_t ed,
                                     input point_t es, input logic [3:0] edep);
    vec_rec_t r;
    r.dir = d; r.point = p; r.normal = n; r.depth = dep;
    r.exp_dir = ed; r.exp_start = es; r.exp_depth = edep;
    return r;
  endfunction

  function automatic logic [191:0] expRay(input point_t s, input vector_t d);
    ray_t r;
    r.start = s;
    r.dir   = d;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [191:0] actual,
                             input logic [191:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // The incident start point is filled with junk; the DUT must ignore it.
  task automatic applyStimulus(input vector_t d, input point_t p, input vector_t n,
                               input logic [3:0] dep);
    ray_t r;
    r.start   = mkp(32'sh0007_7777, 32'sh0007_7777, 32'sh0007_7777);
    r.dir     = d;
    in_ray    = r;
    in_point  = p;
    in_normal = n;
    in_depth  = dep;
    in_valid  = 1'b1;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_ray    = '0;
    in_point  = '0;
    in_normal = '0;
    in_depth  = '0;

    vecs[0] = mkrec(mkv(0, 32'shFFFF_0000, 0), mkp(32'sh2_0000, 0, 32'sh3_0000),
                    mkv(0, 32'sh1_0000, 0), 4'd0,
                    mkv(0, 32'sh1_0000, 0), mkp(32'sh2_0000, 32'sh100, 32'sh3_0000), 4'd1);
    vecs[1] = mkrec(mkv(32'sh8000, 32'shFFFF_8000, 0), mkp(0, 0, 0),
                    mkv(0, 32'sh1_0000, 0), 4'd0,
                    mkv(32'sh8000, 32'sh8000, 0), mkp(0, 32'sh100, 0), 4'd1);
    vecs[2] = mkrec(mkv(32'sh1_0000, 0, 0), mkp(32'sh1_0000, 32'sh2_0000, 32'sh3_0000),
                    mkv(0, 0, 32'sh1_0000), 4'd2,
                    mkv(32'sh1_0000, 0, 0), mkp(32'sh1_0000, 32'sh2_0000, 32'sh3_0100), 4'd3);
    vecs[3] = mkrec(mkv(32'shFFFF_0000, 32'sh1_0000, 0), mkp(0, 0, 0),
                    mkv(32'sh1_0000, 0, 0), 4'd3,
                    mkv(32'sh1_0000, 32'sh1_0000, 0), mkp(32'sh100, 0, 0), 4'd4);
    vecs[4] = mkrec(mkv(0, 32'sh1_0000, 0), mkp(0, 32'sh5_0000, 0),
                    mkv(0, 32'shFFFF_0000, 0), 4'd0,
                    mkv(0, 32'shFFFF_0000, 0), mkp(0, 32'sh4_FF00, 0), 4'd1);
    vecs[5] = mkrec(mkv(0, 0, 32'sh4000), mkp(32'shFFFF_FFFF, 0, 0),
                    mkv(0, 0, 32'sh1_0000), 4'd1,
                    mkv(0, 0, 32'shFFFF_C000), mkp(32'shFFFF_FFFF, 0, 32'sh100), 4'd2);
    vecs[6] = mkrec(mkv(32'sh7FFF_0000, 0, 0), mkp(32'sh7FFF_FFFF, 0, 0),
                    mkv(32'sh1_0000, 0, 0), 4'd0,
                    mkv(32'sh8001_0000, 0, 0), mkp(32'sh8000_00FF, 0, 0), 4'd1);

    // Reset state
    doReset();
    checkOutput("rst_out_valid", 192'(out_valid), 192'(1'b0));
    checkOutput("rst_term_pulse", 192'(term_pulse), 192'(1'b0));
    checkOutput("rst_ray_count", 192'(ray_count), 192'(16'd0));
    checkOutput("rst_out_ray", out_ray, 192'd0);
    checkOutput("rst_out_depth", 192'(out_depth), 192'(4'd0));
    checkOutput("rst_in_ready", 192'(in_ready), 192'(1'b1));

    // Table: one beat at a time, checking latency and result
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].dir, vecs[i].point, vecs[i].normal, vecs[i].depth);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      #1;
      checkOutput($sformatf("vec%0d_early_valid", i), 192'(out_valid), 192'(1'b0));
      @(negedge clk);
      #1;
      checkOutput($sformatf("vec%0d_valid", i), 192'(out_valid), 192'(1'b1));
      checkOutput($sformatf("vec%0d_ray", i), out_ray,
                  expRay(vecs[i].exp_start, vecs[i].exp_dir));
      checkOutput($sformatf("vec%0d_depth", i), 192'(out_depth), 192'(vecs[i].exp_depth));
    end
    @(negedge clk);
    #1;
    checkOutput("table_ray_count", 192'(ray_count), 192'(16'd7));

    // Back-to-back 8 beats with out_ready low in cycles 4..6
    doReset();
    begin
      int sent = 0;
      int got  = 0;
      logic fire_in;
      for (int c = 0; c < 40 && got < 8; c++) begin
        out_ready = !(c >= 4 && c <= 6);
        if (sent < 8) begin
          applyStimulus(mkv(fixed_t'((sent + 1) << 16), 0, 0), mkp(0, fixed_t'(sent + 1), 0),
                        mkv(0, 0, 32'sh1_0000), 4'd0);
        end else begin
          in_valid = 1'b0;
        end
        #1;
        checkOutput($sformatf("stall_in_ready_c%0d", c), 192'(in_ready),
                    192'(!(c >= 4 && c <= 6)));
        if (out_valid && out_ready) begin
          checkOutput($sformatf("stall_ray%0d", got), out_ray,
                      expRay(mkp(0, fixed_t'(got + 1), 32'sh100),
                             mkv(fixed_t'((got + 1) << 16), 0, 0)));
          checkOutput($sformatf("stall_depth%0d", got), 192'(out_depth), 192'(4'd1));
          got++;
        end
        fire_in = in_valid && in_ready;
        @(posedge clk);
        if (fire_in) sent++;
        @(negedge clk);
      end
      in_valid = 1'b0;
      #1;
      checkOutput("stall_outputs_seen", 192'(got), 192'(8));
      checkOutput("stall_ray_count", 192'(ray_count), 192'(16'd8));
      checkOutput("stall_drained", 192'(out_valid), 192'(1'b0));
    end

    // Depth-4 beat is dropped, depth-3 beat goes through
    doReset();
    begin
      int outs   = 0;
      int pulses = 0;
      applyStimulus(vecs[0].dir, vecs[0].point, vecs[0].normal, 4'd4);
      @(posedge clk);
      @(negedge clk);
      applyStimulus(vecs[0].dir, vecs[0].point, vecs[0].normal, 4'd3);
      #1;
      checkOutput("term_pulse_high", 192'(term_pulse), 192'(1'b1));
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checkOutput("term_pulse_low", 192'(term_pulse), 192'(1'b0));
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        #1;
        if (term_pulse) pulses++;
        if (out_valid) begin
          outs++;
          checkOutput("term_out_depth", 192'(out_depth), 192'(4'd4));
          checkOutput("term_out_ray", out_ray, expRay(vecs[0].exp_start, vecs[0].exp_dir));
        end
      end
      checkOutput("term_out_count", 192'(outs), 192'(1));
      checkOutput("term_extra_pulses", 192'(pulses), 192'(0));
      checkOutput("term_ray_count", 192'(ray_count), 192'(16'd1));
    end

    // Reset with two beats in flight
    doReset();
    begin
      int seen = 0;
      applyStimulus(vecs[0].dir, vecs[0].point, vecs[0].normal, 4'd0);
      @(posedge clk);
      @(negedge clk);
      applyStimulus(vecs[1].dir, vecs[1].point, vecs[1].normal, 4'd0);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      rst      = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("flush_in_ready", 192'(in_ready), 192'(1'b1));
      if (out_valid) seen++;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        #1;
        if (out_valid) seen++;
      end
      checkOutput("flush_no_output", 192'(seen), 192'(0));
      checkOutput("flush_ray_count", 192'(ray_count), 192'(16'd0));
    end

    // ray_count wrap: 65535 rays, then one more
    doReset();
    applyStimulus(vecs[2].dir, vecs[2].point, vecs[2].normal, 4'd0);
    repeat (65535) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    checkOutput("wrap_count_ffff", 192'(ray_count), 192'(16'hFFFF));
    applyStimulus(vecs[2].dir, vecs[2].point, vecs[2].normal, 4'd0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    checkOutput("wrap_count_zero", 192'(ray_count), 192'(16'h0000));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/reflect_ray_gen.md
REFLECT_RAY_GEN -- requirements
Module: reflect_ray_gen

Interface
REQ-001 SHALL have parameter MAX_BOUNCE, default 4, the bounce depth at which a ray is terminated instead of reflected.
REQ-002 SHALL have parameter EPS, default 32'h0000_0100 (1/256), the offset along the normal applied to the new ray start.
REQ-003 SHALL have port clk  input  1  the single clock; all logic rising-edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  the input beat is valid.
REQ-006 SHALL have port in_ready  output  1  the block accepts the input beat this cycle.
REQ-007 SHALL have port in_ray  input  192  incident ray (start point, dir vector), each 3x fixed.
REQ-008 SHALL have port in_point  input  96  intersection point.
REQ-009 SHALL have port in_normal  input  96  unit surface normal.
REQ-010 SHALL have port in_depth  input  4  bounce depth of the incident ray.
REQ-011 SHALL have port out_valid  output  1  the reflected ray is valid.
REQ-012 SHALL have port out_ready  input  1  the consumer accepts out_ray.
REQ-013 SHALL have port out_ray  output  192  reflected ray.
REQ-014 SHALL have port out_depth  output  4  in_depth+1.
REQ-015 SHALL have port term_pulse  output  1  one-cycle pulse per terminated ray.
REQ-016 SHALL have port ray_count  output  16  count of emitted reflected rays.

Function
REQ-017 fixed SHALL be signed 32-bit Q16.16; multiply SHALL be fMul: 64-bit product, arithmetic shift right 16, low 32 bits kept (wrap, no saturation); add/sub SHALL wrap at 32 bits.
REQ-018 A transfer SHALL occur on a cycle where valid and ready are both high; data held stable while valid && !ready.
REQ-019 Pipeline SHALL be 3 stages: S1 dot = d.n; S2 kn = fMul(2*dot, n), en = fMul(EPS, n); S3 dir' = d - kn, start' = in_point + en.
REQ-020 Latency SHALL be exactly 3 cycles from an accepted beat to out_valid with no stall; throughput 1 beat/cycle.
REQ-021 advance = !out_valid || out_ready; all stages SHALL shift only when advance is high; in_ready SHALL equal advance.
REQ-022 With advance low, every stage register, out_ray and out_depth SHALL hold.
REQ-023 An accepted beat with in_depth >= MAX_BOUNCE SHALL NOT enter the pipeline; term_pulse SHALL be high the following cycle only.
REQ-024 Accepted non-terminated beats on consecutive cycles SHALL each produce an independent output; no bubbles inserted.
REQ-025 ray_count SHALL increment on each out_valid && out_ready and wrap 16'hFFFF -> 0.
REQ-026 in_depth = 4'hF below MAX_BOUNCE is impossible with defaults; out_depth SHALL wrap modulo 16 if MAX_BOUNCE > 15.

Reset
REQ-027 On rst: all stage valid bits, out_valid, term_pulse = 0; ray_count = 0; out_ray, out_depth = 0.
REQ-028 Reset mid-operation SHALL discard all in-flight beats; no output for them after rst deasserts.
REQ-029 in_ready SHALL be 1 in the cycle after rst deasserts.

Structure
REQ-030 fixed, point, vector, ray typedefs and fMul SHALL come from the shared definitions/math packages; FIXED_ONE, MAX_BOUNCE default and EPS default SHALL live in light_pack.
REQ-031 One sub-module, vec_dot3, SHALL compute the registered 3-term fixed dot product for S1.

Verification
REQ-032 dir (0,-1.0,0), n (0,1.0,0), point (2.0,0,3.0), depth 0 -> after 3 cycles dir' (0,1.0,0), start' (0x20000,0x100,0x30000), depth 1.
REQ-033 dir (0.5,-0.5,0), n (0,1.0,0) -> dir' (0x8000,0x8000,0).
REQ-034 Back-to-back 8 beats, out_ready low cycles 4-6 -> in_ready low those cycles, all 8 outputs in order, none lost, ray_count = 8.
REQ-035 depth 4 beat then depth 3 beat -> term_pulse one cycle after first; only second emitted, out_depth 4.
REQ-036 rst asserted while 2 beats in flight -> no out_valid after release; ray_count 0.
REQ-037 ray_count preloaded to 0xFFFF via 65535 emitted rays, one more -> 0x0000.
